multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Iterative signed multiply/divide unit for the execute stage.
- Reuses one WIDTH-bit add/subtract path over WIDTH cycles instead of a combinational array.
- Multiply uses radix-2 Booth; divide uses non-restoring division on magnitudes with a final sign fix-up.
- The pipeline stalls from the ctrl pulse until data_resultRDY.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH; counter is clog2(WIDTH)+1 bits.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
data_operandB  input  WIDTH  multiplier / divisor (two's complement)
ctrl_MULT  input  1  one-cycle start pulse for multiply
ctrl_DIV  input  1  one-cycle start pulse for divide
data_result  output  WIDTH  product low word / quotient
data_exception  output  1  overflow or divide-by-zero flag, valid with data_resultRDY
data_resultRDY  output  1  one-cycle done pulse
busy  output  1  high from the cycle after the start edge until the RDY cycle, inclusive

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE, counter=0, all datapath registers cleared.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset mid-operation aborts the operation; no RDY is issued.
- States:
  - IDLE.
  - MULT: WIDTH iterations.
  - DIV: WIDTH iterations.
  - DONE: one cycle, asserts RDY.
- Start: a start is any edge where ctrl_MULT or ctrl_DIV is high, in any state.
  - Latches both operands, clears the counter and enters MULT or DIV.
  - ctrl_MULT has priority if both are high.
  - A start while MULT/DIV/DONE is in progress aborts the current operation and restarts with the new operands. The aborted operation never asserts RDY.
- MULT:
  - Product register P is {WIDTH-bit upper, WIDTH-bit lower=B, 1-bit extra=0}.
  - Each cycle, examine the low 2 bits of P:
    - 01: upper += A.
    - 10: upper -= A (add ~A with carry-in 1).
    - 00 or 11: no add.
  - Then arithmetic-shift P right by 1.
  - After WIDTH iterations, go to DONE.
- DIV:
  - If B==0 on the start edge: go directly to DONE with result=0 and exception=1. RDY comes 1 cycle after the start edge.
  - Otherwise take |A| and |B|, then run WIDTH non-restoring iterations:
    - Shift {R,Q} left.
    - R = R−|B| if R≥0 (sign bit 0), else R = R+|B|.
    - Q[0] = ~R[sign].
  - Remainder correction is not required; the remainder is not output.
  - Quotient sign = A[msb]^B[msb]. Negate when set.
  - Result truncates toward zero.
- DONE (registered outputs update on entry):
  - MULT: data_result = low WIDTH bits of the product. data_exception=1 iff the upper WIDTH bits are not all equal to product bit WIDTH−1, i.e. the result does not fit.
  - DIV: data_result = quotient, data_exception=0. Special case: A=−2^(WIDTH−1) with B=−1 gives result 0x80000000 and exception=1.
- Latency:
  - RDY is high in the cycle after the final (WIDTH-th) iteration edge, i.e. WIDTH+1 cycles after the start edge (33 for WIDTH=32).
  - RDY is high for exactly one cycle. DONE then returns to IDLE.
- Hold: data_result and data_exception hold their last values until the next DONE entry or reset.
- Inputs: operand inputs are ignored except on start edges.
- Counter: saturates; it must not wrap into a second RDY.

Test Plan:
- Reset: hold reset_n=0, pulse clock, release -> result=0, exception=0, RDY=0, busy=0. Assert reset_n=0 mid-MULT -> immediate clear, no RDY afterwards.
- Multiply: A=7, B=−3, ctrl_MULT at edge 0 -> RDY exactly at cycle 33, result=0xFFFFFFEB (−21), exception=0. A=0x00010000, B=0x00010000 -> result=0, exception=1.
- Multiply extremes: A=−2^31, B=1 -> 0x80000000, exc=0. A=−2^31, B=−1 -> exc=1.
- Divide: A=−100, B=7 -> RDY at cycle 33, result=0xFFFFFFF2 (−14), exc=0. A=100, B=0 -> RDY at cycle 1, result=0, exc=1. A=0x80000000, B=−1 -> result=0x80000000, exc=1.
- Restart: ctrl_MULT (A=3, B=4), then ctrl_DIV (A=20, B=5) at cycle 10 -> single RDY at cycle 43, result=4. Simultaneous ctrl_MULT and ctrl_DIV (A=6, B=2) -> 12.
- Hold and random: result stays stable for 20 idle cycles after RDY. 1000 random operand pairs for each op are checked against a signed reference model, including exception flags.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - iterative signed multiply (radix-2 Booth) / divide (non-restoring) unit
`timescale 1ns/1ps
module multdiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   r_acc;     // Booth upper word / division partial remainder, one guard bit
   logic [WIDTH-1:0] r_lo;      // multiplier bits / quotient bits
   logic             r_x;       // Booth extra bit
   logic [WIDTH-1:0] r_m;       // multiplicand / divisor magnitude
   logic             r_neg;
   logic             r_ovf;
   logic             r_dz;
   logic [WIDTH-1:0] r_result;
   logic             r_exc;

   logic             w_start;
   logic             w_last;
   logic             w_sub;
   logic [WIDTH:0]   w_opa;
   logic [WIDTH:0]   w_opb;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_quot;
   logic             w_mult_exc;

   assign w_start    = ctrl_MULT | ctrl_DIV;
   assign w_last     = (r_cnt == LAST);
   assign w_abs_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign w_abs_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   assign w_quot     = r_neg ? -r_lo : r_lo;
   assign w_mult_exc = (r_acc[WIDTH-1:0] != {WIDTH{r_lo[WIDTH-1]}});

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_start) begin
         w_next = ctrl_MULT ? S_MULT : S_DIV;
      end else begin
         case (r_state)
            S_MULT, S_DIV: if (w_last) w_next = S_DONE;
            S_DONE:        w_next = S_IDLE;
            default:       w_next = r_state;
         endcase
      end
   end

   // Single shared adder: Booth add/sub of the multiplicand, or the non-restoring step
   always_comb begin
      w_opa = r_acc;
      w_opb = '0;
      w_sub = 1'b0;
      if (r_state == S_DIV) begin
         w_opa = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
         w_opb = {1'b0, r_m};
         w_sub = ~r_acc[WIDTH];
      end else begin
         case ({r_lo[0], r_x})
            2'b01:   w_opb = {r_m[WIDTH-1], r_m};
            2'b10: begin
               w_opb = {r_m[WIDTH-1], r_m};
               w_sub = 1'b1;
            end
            default: w_opb = '0;
         endcase
      end
      w_sum = w_opa + (w_sub ? ~w_opb : w_opb) + {{WIDTH{1'b0}}, w_sub};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_lo     <= '0;
         r_x      <= 1'b0;
         r_m      <= '0;
         r_neg    <= 1'b0;
         r_ovf    <= 1'b0;
         r_dz     <= 1'b0;
         r_result <= '0;
         r_exc    <= 1'b0;
      end else if (w_start) begin
         r_cnt <= '0;
         r_acc <= '0;
         r_x   <= 1'b0;
         if (ctrl_MULT) begin
            r_m   <= data_operandA;
            r_lo  <= data_operandB;
            r_neg <= 1'b0;
            r_ovf <= 1'b0;
            r_dz  <= 1'b0;
         end else begin
            r_m   <= w_abs_b;
            r_lo  <= w_abs_a;
            r_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_ovf <= (data_operandA == MIN_NEG) && (data_operandB == '1);
            r_dz  <= (data_operandB == '0);
            // Divide-by-zero skips the iterations and completes on the next edge
            if (data_operandB == '0) r_cnt <= LAST;
         end
      end else if (r_state == S_MULT || r_state == S_DIV) begin
         if (!w_last) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_state == S_MULT) begin
               r_acc <= {w_sum[WIDTH], w_sum[WIDTH:1]};
               r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
               r_x   <= r_lo[0];
            end else begin
               r_acc <= w_sum;
               r_lo  <= {r_lo[WIDTH-2:0], ~w_sum[WIDTH]};
            end
         end else if (r_state == S_MULT) begin
            r_result <= r_lo;
            r_exc    <= w_mult_exc;
         end else begin
            r_result <= r_dz ? '0 : w_quot;
            r_exc    <= r_dz | r_ovf;
         end
      end
   end

   assign data_result    = r_result;
   assign data_exception = r_exc;
   assign data_resultRDY = (r_state == S_DONE);
   assign busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - scoreboard bench for multdiv_ctrl against an arithmetic reference model
`timescale 1ns/1ps
module tb_multdiv_ctrl;
   localparam int W = 32;
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          c_mult = 1'b0;
   logic          c_div = 1'b0;
   logic [W-1:0]  result;
   logic          exc;
   logic          rdy;
   logic          busy;

   multdiv_ctrl #(.WIDTH(W)) dut (
      .clock(clock), .reset_n(reset_n),
      .data_operandA(op_a), .data_operandB(op_b),
      .ctrl_MULT(c_mult), .ctrl_DIV(c_div),
      .data_result(result), .data_exception(exc),
      .data_resultRDY(rdy), .busy(busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          at;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_res = '0;
   logic        last_exc = 1'b0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   function automatic void model(input bit is_mult, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic e);
      longint p;
      int     xi;
      int     yi;
      if (is_mult) begin
         p = longint'(signed'(x)) * longint'(signed'(y));
         r = p[31:0];
         e = (p != longint'(signed'(r)));
      end else if (y == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (x == MINV && y == 32'hFFFF_FFFF) begin
         r = MINV;
         e = 1'b1;
      end else begin
         xi = x;
         yi = y;
         r  = xi / yi;
         e  = 1'b0;
      end
   endfunction

   always @(negedge clock) begin
      if (reset_n && rdy) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rdy: got rdy=1 result=%h expected no rdy (cycle %0d)", result, cyc);
         end else begin
            cur = sb.pop_front();
            chk("result", result, cur.res);
            chk("exception", {31'd0, exc}, {31'd0, cur.exc});
            chk("rdy_cycle", cyc, cur.at);
            last_res = cur.res;
            last_exc = cur.exc;
         end
      end
   end

   task automatic start(input bit m, input bit d, input logic [31:0] x, input logic [31:0] y,
                        input bit push);
      exp_t        e;
      logic [31:0] r;
      logic        ex;
      @(negedge clock);
      op_a = x; op_b = y; c_mult = m; c_div = d;
      @(posedge clock);
      #1;
      c_mult = 1'b0; c_div = 1'b0;
      op_a = $urandom; op_b = $urandom;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      if (push) begin
         model(m, x, y, r, ex);
         e.res = r;
         e.exc = ex;
         e.at  = cyc + ((!m && y == 32'd0) ? 1 : W + 1);
         sb.push_back(e);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 80) begin
         @(posedge clock);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL rdy_timeout: got no rdy after %0d cycles expected rdy", n);
         sb.delete();
      end
      @(posedge clock);
      #1;
      chk("busy_after_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic run(input bit m, input bit d, input logic [31:0] x, input logic [31:0] y);
      start(m, d, x, y, 1'b1);
      wait_done();
   endtask

   function automatic logic [31:0] rnd_operand();
      logic [31:0] v;
      case ($urandom_range(0, 3))
         0: v = $urandom;
         1: v = 32'($urandom_range(0, 200)) - 32'd100;
         2: case ($urandom_range(0, 4))
               0: v = 32'd0;
               1: v = 32'd1;
               2: v = 32'hFFFF_FFFF;
               3: v = MINV;
               default: v = 32'h7FFF_FFFF;
            endcase
         default: v = {{16{1'b0}}, 16'($urandom)} ^ ($urandom_range(0, 1) != 0 ? 32'hFFFF_0000 : 32'h0);
      endcase
      return v;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_result", result, 32'd0);
      chk("reset_exception", {31'd0, exc}, 32'd0);
      chk("reset_rdy", {31'd0, rdy}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      run(1, 0, 32'd7, -32'sd3);
      run(1, 0, 32'h0001_0000, 32'h0001_0000);
      run(1, 0, MINV, 32'd1);
      run(1, 0, MINV, 32'hFFFF_FFFF);
      run(0, 1, -32'sd100, 32'd7);
      run(0, 1, 32'd100, 32'd0);
      run(0, 1, MINV, 32'hFFFF_FFFF);

      start(1, 0, 32'd3, 32'd4, 1'b0);
      repeat (9) @(posedge clock);
      start(0, 1, 32'd20, 32'd5, 1'b1);
      wait_done();

      run(1, 1, 32'd6, 32'd2);

      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         op_a = $urandom; op_b = $urandom;
         chk("hold_result", result, last_res);
         chk("hold_exception", {31'd0, exc}, {31'd0, last_exc});
      end

      start(1, 0, 32'h1234, 32'h5678, 1'b0);
      repeat (10) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      chk("midreset_result", result, 32'd0);
      chk("midreset_exception", {31'd0, exc}, 32'd0);
      chk("midreset_rdy", {31'd0, rdy}, 32'd0);
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (40) @(posedge clock);

      for (int i = 0; i < 2000; i++) begin
         if (i % 2 == 0) run(1, 0, rnd_operand(), rnd_operand());
         else            run(0, 1, rnd_operand(), rnd_operand());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
